// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Memory-side responder for the decoder's MEM controls. Converts one
//   load/store request into a single word-aligned data-bus transaction with
//   byte enables, returns aligned and sign/zero-extended load data, and stalls
//   the core while the bus is busy.
//
// Optional feature macro: LSU_TIMEOUT_EN
//   defined   : a 16-bit counter aborts a BUS wait after TIMEOUT_CYCLES
//               bus_req cycles without bus_ack (response with bus_error=1)
//   undefined : BUS waits indefinitely, bus_error is tied low
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready request handshake from the MEM stage
//   MemRead, MemWrite   load / store request (store wins if both are set)
//   MemDataMask         01 byte, 10 half, 11/00 word
//   MemReadSignExtend   1 sign-extend loads, 0 zero-extend
//   addr, wdata         byte address and store data (LSBs significant)
//   resp_valid          1-cycle completion pulse
//   rdata               extended load data, valid with resp_valid
//   misaligned          qualifies resp_valid: no bus cycle was issued
//   bus_error           qualifies resp_valid: bus timeout
//   stall               hold the pipeline
//   bus_req..bus_wdata  registered data-bus request
//   bus_ack, bus_rdata  data-bus completion and read word
// -----------------------------------------------------------------------------
module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  MemDataMask,
   input  logic        MemReadSignExtend,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        resp_valid,
   output logic [31:0] rdata,
   output logic        misaligned,
   output logic        bus_error,
   output logic        stall,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUS,
      S_RESP
   } state_t;

   state_t      state_q, state_d;
   logic        bus_req_q, bus_req_d;
   logic        bus_we_q, bus_we_d;
   logic [31:0] bus_addr_q, bus_addr_d;
   logic [3:0]  bus_be_q, bus_be_d;
   logic [31:0] bus_wdata_q, bus_wdata_d;
   logic [1:0]  mask_q, mask_d;
   logic        sext_q, sext_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] rdata_q, rdata_d;
   logic        mis_q, mis_d;

   logic        accept;
   logic        req_byte, req_half, req_mis;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic [31:0] shifted;
   logic [31:0] load_ext;
   logic        timeout_hit;

`ifdef LSU_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] cnt_q, cnt_d;
   logic        err_q, err_d;
`endif

   // Request decode (combinational on the live request fields)
   always_comb begin
      accept    = (state_q == S_IDLE) && req_valid && (MemRead || MemWrite);
      req_byte  = (MemDataMask == 2'b01);
      req_half  = (MemDataMask == 2'b10);
      req_mis   = (req_half && addr[0]) ||
                  (!req_byte && !req_half && (addr[1:0] != 2'b00));
      req_be    = 4'b1111;
      req_wdata = wdata;
      if (req_byte) begin
         req_be    = 4'b0001 << addr[1:0];
         req_wdata = {4{wdata[7:0]}};
      end else if (req_half) begin
         req_be    = addr[1] ? 4'b1100 : 4'b0011;
         req_wdata = {2{wdata[15:0]}};
      end
   end

   // Load alignment: bring the addressed lane down to bit 0, then extend
   always_comb begin
      shifted  = bus_rdata >> {off_q, 3'b000};
      load_ext = shifted;
      if (mask_q == 2'b01) begin
         load_ext = {{24{sext_q & shifted[7]}}, shifted[7:0]};
      end else if (mask_q == 2'b10) begin
         load_ext = {{16{sext_q & shifted[15]}}, shifted[15:0]};
      end
   end

`ifdef LSU_TIMEOUT_EN
   assign timeout_hit = (cnt_q == TO_LAST);
`else
   assign timeout_hit = 1'b0;
`endif

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;
      mask_d      = mask_q;
      sext_d      = sext_q;
      off_d       = off_q;
      rdata_d     = rdata_q;
      mis_d       = mis_q;
`ifdef LSU_TIMEOUT_EN
      cnt_d       = cnt_q;
      err_d       = err_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               bus_we_d    = MemWrite;
               bus_addr_d  = {addr[31:2], 2'b00};
               bus_be_d    = req_be;
               bus_wdata_d = req_wdata;
               mask_d      = MemDataMask;
               sext_d      = MemReadSignExtend;
               off_d       = addr[1:0];
               rdata_d     = '0;
               mis_d       = req_mis;
`ifdef LSU_TIMEOUT_EN
               cnt_d       = '0;
               err_d       = 1'b0;
`endif
               if (req_mis) begin
                  state_d   = S_RESP;
                  bus_req_d = 1'b0;
               end else begin
                  state_d   = S_BUS;
                  bus_req_d = 1'b1;
               end
            end
         end
         S_BUS: begin
            // An ack on the final allowed cycle still completes normally
            if (bus_ack) begin
               state_d   = S_RESP;
               bus_req_d = 1'b0;
               rdata_d   = bus_we_q ? '0 : load_ext;
            end else if (timeout_hit) begin
               state_d   = S_RESP;
               bus_req_d = 1'b0;
               rdata_d   = '0;
`ifdef LSU_TIMEOUT_EN
               err_d     = 1'b1;
`endif
            end else begin
`ifdef LSU_TIMEOUT_EN
               cnt_d = cnt_q + 16'd1;
`endif
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d   = S_IDLE;
            bus_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_be_q    <= '0;
         bus_wdata_q <= '0;
         mask_q      <= '0;
         sext_q      <= 1'b0;
         off_q       <= '0;
         rdata_q     <= '0;
         mis_q       <= 1'b0;
`ifdef LSU_TIMEOUT_EN
         cnt_q       <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
         mask_q      <= mask_d;
         sext_q      <= sext_d;
         off_q       <= off_d;
         rdata_q     <= rdata_d;
         mis_q       <= mis_d;
`ifdef LSU_TIMEOUT_EN
         cnt_q       <= cnt_d;
         err_q       <= err_d;
`endif
      end
   end

   // Outputs
   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = (state_q == S_RESP);
   assign rdata      = resp_valid ? rdata_q : '0;
   assign misaligned = resp_valid & mis_q;
`ifdef LSU_TIMEOUT_EN
   assign bus_error  = resp_valid & err_q;
`else
   assign bus_error  = 1'b0;
`endif
   assign stall      = accept || (state_q == S_BUS);
   assign bus_req    = bus_req_q;
   assign bus_we     = bus_we_q;
   assign bus_addr   = bus_addr_q;
   assign bus_be     = bus_be_q;
   assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//   Directed self-checking bench for load_store_unit. Inputs are driven at
//   the falling edge or 1 time unit after the rising edge; outputs are
//   sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        MemRead;
   logic        MemWrite;
   logic [1:0]  MemDataMask;
   logic        MemReadSignExtend;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        resp_valid;
   logic [31:0] rdata;
   logic        misaligned;
   logic        bus_error;
   logic        stall;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   load_store_unit #(
`ifdef LSU_TIMEOUT_EN
      .TIMEOUT_CYCLES(4)
`else
      .TIMEOUT_CYCLES(255)
`endif
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .MemRead           (MemRead),
      .MemWrite          (MemWrite),
      .MemDataMask       (MemDataMask),
      .MemReadSignExtend (MemReadSignExtend),
      .addr              (addr),
      .wdata             (wdata),
      .resp_valid        (resp_valid),
      .rdata             (rdata),
      .misaligned        (misaligned),
      .bus_error         (bus_error),
      .stall             (stall),
      .bus_req           (bus_req),
      .bus_we            (bus_we),
      .bus_addr          (bus_addr),
      .bus_be            (bus_be),
      .bus_wdata         (bus_wdata),
      .bus_ack           (bus_ack),
      .bus_rdata         (bus_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Drive one request in the falling-edge half of a cycle
   task automatic drive_req(input logic rd, input logic wr, input logic [1:0] mask,
                            input logic sx, input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      req_valid         = 1'b1;
      MemRead           = rd;
      MemWrite          = wr;
      MemDataMask       = mask;
      MemReadSignExtend = sx;
      addr              = a;
      wdata             = wd;
   endtask

   // Full aligned transaction: accept, ack after 'delay' extra bus_req cycles, response
   task automatic access(input string tag, input logic rd, input logic wr,
                         input logic [1:0] mask, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int unsigned delay, input logic [31:0] rword,
                         input logic exp_we, input logic [31:0] exp_addr,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_rdata);
      drive_req(rd, wr, mask, sx, a, wd);
      #1;
      chk({tag, ".acc_stall"}, 32'(stall), 32'd1);
      chk({tag, ".acc_ready"}, 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk({tag, ".bus_req"},   32'(bus_req), 32'd1);
      chk({tag, ".bus_we"},    32'(bus_we), 32'(exp_we));
      chk({tag, ".bus_addr"},  bus_addr, exp_addr);
      chk({tag, ".bus_be"},    32'(bus_be), 32'(exp_be));
      chk({tag, ".bus_wdata"}, bus_wdata, exp_wdata);
      chk({tag, ".bus_ready"}, 32'(req_ready), 32'd0);
      for (int unsigned i = 0; i < delay; i++) begin
         @(posedge clk); #1;
         chk({tag, ".wait_req"},   32'(bus_req), 32'd1);
         chk({tag, ".wait_stall"}, 32'(stall), 32'd1);
         chk({tag, ".wait_addr"},  bus_addr, exp_addr);
         chk({tag, ".wait_be"},    32'(bus_be), 32'(exp_be));
         chk({tag, ".wait_wdata"}, bus_wdata, exp_wdata);
         chk({tag, ".wait_resp"},  32'(resp_valid), 32'd0);
      end
      bus_ack   = 1'b1;
      bus_rdata = rword;
      @(posedge clk); #1;
      bus_ack   = 1'b0;
      bus_rdata = 32'h5A5A_5A5A;
      chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, ".rdata"},      rdata, exp_rdata);
      chk({tag, ".misaligned"}, 32'(misaligned), 32'd0);
      chk({tag, ".bus_error"},  32'(bus_error), 32'd0);
      chk({tag, ".resp_busreq"}, 32'(bus_req), 32'd0);
      chk({tag, ".resp_stall"}, 32'(stall), 32'd0);
      @(posedge clk); #1;
      chk({tag, ".pulse_end"}, 32'(resp_valid), 32'd0);
      chk({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
   endtask

   task automatic misaligned_access(input string tag, input logic rd, input logic wr,
                                    input logic [1:0] mask, input logic [31:0] a);
      drive_req(rd, wr, mask, 1'b1, a, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk({tag, ".no_bus_req"}, 32'(bus_req), 32'd0);
      chk({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
      chk({tag, ".misaligned"}, 32'(misaligned), 32'd1);
      chk({tag, ".rdata"},      rdata, 32'h0);
      chk({tag, ".stall"},      32'(stall), 32'd0);
      @(posedge clk); #1;
      chk({tag, ".pulse_end"},  32'(resp_valid), 32'd0);
      chk({tag, ".ready"},      32'(req_ready), 32'd1);
   endtask

   initial begin
      rst               = 1'b1;
      req_valid         = 1'b0;
      MemRead           = 1'b0;
      MemWrite          = 1'b0;
      MemDataMask       = 2'b00;
      MemReadSignExtend = 1'b0;
      addr              = '0;
      wdata             = '0;
      bus_ack           = 1'b0;
      bus_rdata         = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst.req_ready",  32'(req_ready), 32'd1);
      chk("rst.resp_valid", 32'(resp_valid), 32'd0);
      chk("rst.bus_req",    32'(bus_req), 32'd0);
      chk("rst.stall",      32'(stall), 32'd0);
      chk("rst.rdata",      rdata, 32'h0);
      chk("rst.bus_be",     32'(bus_be), 32'h0);
      chk("rst.misaligned", 32'(misaligned), 32'd0);
      chk("rst.bus_error",  32'(bus_error), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // lw 0x100, ack on first bus cycle
      access("lw100", 1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0, 0,
             32'hDEAD_BEEF, 1'b0, 32'h0000_0100, 4'b1111, 32'h0, 32'hDEAD_BEEF);
      // lb 0x103 signed / unsigned
      access("lb103", 1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0103, 32'h0, 0,
             32'h8011_2233, 1'b0, 32'h0000_0100, 4'b1000, 32'h0, 32'hFFFF_FF80);
      access("lbu103", 1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0103, 32'h0, 0,
             32'h8011_2233, 1'b0, 32'h0000_0100, 4'b1000, 32'h0, 32'h0000_0080);
      // sh 0x202
      access("sh202", 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 0,
             32'h1111_1111, 1'b1, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0);
      // sb 0x1: lane 1, replicated byte
      access("sb001", 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0001, 32'h1234_5678, 0,
             32'h0, 1'b1, 32'h0000_0000, 4'b0010, 32'h7878_7878, 32'h0);
      // lhu 0x2: upper half zero-extended
      access("lhu002", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0, 1,
             32'hBEEF_0000, 1'b0, 32'h0000_0000, 4'b1100, 32'h0, 32'h0000_BEEF);
      // Mask 00 treated as word; both MemRead and MemWrite -> store wins
      access("both00", 1'b1, 1'b1, 2'b00, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 0,
             32'hFFFF_FFFF, 1'b1, 32'h0000_0010, 4'b1111, 32'hCAFE_F00D, 32'h0);
      // lh 0x0 signed, ack delayed 5 cycles
      access("lh_wait", 1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_0000, 32'h0, 5,
             32'h1234_8001, 1'b0, 32'h0000_0000, 4'b0011, 32'h0, 32'hFFFF_8001);

      // Misaligned word load and half store
      misaligned_access("lw101", 1'b1, 1'b0, 2'b11, 32'h0000_0101);
      misaligned_access("sh203", 1'b0, 1'b1, 2'b10, 32'h0000_0203);

      // req_valid with neither MemRead nor MemWrite is ignored
      drive_req(1'b0, 1'b0, 2'b11, 1'b0, 32'h0000_0400, 32'h0);
      #1;
      chk("nop.stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("nop.bus_req", 32'(bus_req), 32'd0);
      chk("nop.ready",   32'(req_ready), 32'd1);
      chk("nop.resp",    32'(resp_valid), 32'd0);

      // bus_ack while idle is ignored
      @(negedge clk);
      bus_ack = 1'b1;
      @(posedge clk); #1;
      bus_ack = 1'b0;
      chk("idle_ack.resp",  32'(resp_valid), 32'd0);
      chk("idle_ack.ready", 32'(req_ready), 32'd1);

      // Reset during a bus wait drops the transaction immediately
      drive_req(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0300, 32'h0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rstmid.bus_req_before", 32'(bus_req), 32'd1);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("rstmid.bus_req",    32'(bus_req), 32'd0);
      chk("rstmid.resp_valid", 32'(resp_valid), 32'd0);
      chk("rstmid.ready",      32'(req_ready), 32'd1);
      chk("rstmid.stall",      32'(stall), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rstmid.no_replay_req",  32'(bus_req), 32'd0);
      chk("rstmid.no_replay_resp", 32'(resp_valid), 32'd0);

      // Back-to-back after reset recovery
      access("lw_after_rst", 1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0104, 32'h0, 0,
             32'h0102_0304, 1'b0, 32'h0000_0104, 4'b1111, 32'h0, 32'h0102_0304);

`ifdef LSU_TIMEOUT_EN
      // No ack: bus_req for 4 cycles, then bus_error response
      drive_req(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0500, 32'h0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("to.req_c1", 32'(bus_req), 32'd1);
      for (int unsigned i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("to.req_cn", 32'(bus_req), 32'd1);
         chk("to.no_resp", 32'(resp_valid), 32'd0);
      end
      @(posedge clk); #1;
      chk("to.resp_valid", 32'(resp_valid), 32'd1);
      chk("to.bus_error",  32'(bus_error), 32'd1);
      chk("to.bus_req",    32'(bus_req), 32'd0);
      chk("to.rdata",      rdata, 32'h0);
      @(posedge clk); #1;
      chk("to.pulse_end",  32'(resp_valid), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
